// File: rtl/decode_prefix_modrm.sv
// Byte-serial decode front end: absorbs prefixes, one/two-byte opcode and ModRM,
// then holds a registered record for decode_general_register until end-of-instruction.
module decode_prefix_modrm #(
    parameter int MAX_LEN = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    input  logic       cs_d,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       instr_end,
    output logic [7:0] opcode,
    output logic       two_byte,
    output logic       has_modrm,
    output logic [1:0] mod,
    output logic [2:0] instruction_reg,
    output logic [2:0] rm,
    output logic       w_is_present,
    output logic       w,
    output logic       bit_width_16,
    output logic       bit_width_32,
    output logic       addr_size_32,
    output logic       lock,
    output logic       rep,
    output logic       repne,
    output logic       seg_valid,
    output logic [2:0] seg,
    output logic       fault
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_PREFIX   = 3'd0,
        S_OPCODE2  = 3'd1,
        S_MODRM    = 3'd2,
        S_OUT      = 3'd3,
        S_WAIT_END = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_pfx_q, op_pfx_d;
    logic               ad_pfx_q, ad_pfx_d;
    logic               byte_ready_q, byte_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         opcode_q, opcode_d;
    logic               two_byte_q, two_byte_d;
    logic               has_modrm_q, has_modrm_d;
    logic [1:0]         mod_q, mod_d;
    logic [2:0]         ireg_q, ireg_d;
    logic [2:0]         rm_q, rm_d;
    logic               wp_q, wp_d;
    logic               w_q, w_d;
    logic               bw16_q, bw16_d;
    logic               bw32_q, bw32_d;
    logic               as32_q, as32_d;
    logic               lock_q, lock_d;
    logic               rep_q, rep_d;
    logic               repne_q, repne_d;
    logic               segv_q, segv_d;
    logic [2:0]         seg_q, seg_d;
    logic               fault_q, fault_d;

    function automatic logic is_prefix(input logic [7:0] b);
        return b inside {8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3,
                         8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
    endfunction

    function automatic logic [2:0] seg_code(input logic [7:0] b);
        logic [2:0] s;
        case (b)
            8'h26:   s = 3'd0;
            8'h2E:   s = 3'd1;
            8'h36:   s = 3'd2;
            8'h3E:   s = 3'd3;
            8'h64:   s = 3'd4;
            8'h65:   s = 3'd5;
            default: s = 3'd0;
        endcase
        return s;
    endfunction

    // ALU r/m forms: 00xx_x0xx (ADD/OR/ADC/SBB/AND/SUB/XOR/CMP with ModRM)
    function automatic logic is_alu(input logic [7:0] op);
        return (op[7:6] == 2'b00) && !op[2];
    endfunction

    function automatic logic modrm_1b(input logic [7:0] op);
        return is_alu(op)
            || (op inside {8'h62, 8'h63, 8'h69, 8'h6B})
            || (op[7:4] == 4'h8)
            || (op inside {8'hC0, 8'hC1, 8'hC6, 8'hC7})
            || (op[7:2] == 6'b1101_00)
            || (op inside {8'hF6, 8'hF7, 8'hFE, 8'hFF});
    endfunction

    function automatic logic modrm_2b(input logic [7:0] op);
        return !((op[7:4] == 4'h8) || (op inside {8'hA0, 8'hA1, 8'hA8, 8'hA9}));
    endfunction

    function automatic logic w_in_bit0(input logic [7:0] op);
        return is_alu(op)
            || (op[7:2] == 6'b1000_01)
            || (op[7:2] == 6'b1000_10)
            || (op[7:1] == 7'b1100_011)
            || (op[7:2] == 6'b1101_00)
            || (op[7:1] == 7'b1111_011)
            || (op[7:1] == 7'b1111_111);
    endfunction

    function automatic logic reg_in_opcode(input logic [7:0] op);
        return (op[7:5] == 3'b010) || (op[7:3] == 5'b1001_0) || (op[7:4] == 4'hB);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_PREFIX;
            cnt_q        <= '0;
            op_pfx_q     <= 1'b0;
            ad_pfx_q     <= 1'b0;
            byte_ready_q <= 1'b1;
            out_valid_q  <= 1'b0;
            opcode_q     <= 8'h00;
            two_byte_q   <= 1'b0;
            has_modrm_q  <= 1'b0;
            mod_q        <= 2'd0;
            ireg_q       <= 3'd0;
            rm_q         <= 3'd0;
            wp_q         <= 1'b0;
            w_q          <= 1'b0;
            bw16_q       <= 1'b0;
            bw32_q       <= 1'b0;
            as32_q       <= 1'b0;
            lock_q       <= 1'b0;
            rep_q        <= 1'b0;
            repne_q      <= 1'b0;
            segv_q       <= 1'b0;
            seg_q        <= 3'd0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_pfx_q     <= op_pfx_d;
            ad_pfx_q     <= ad_pfx_d;
            byte_ready_q <= byte_ready_d;
            out_valid_q  <= out_valid_d;
            opcode_q     <= opcode_d;
            two_byte_q   <= two_byte_d;
            has_modrm_q  <= has_modrm_d;
            mod_q        <= mod_d;
            ireg_q       <= ireg_d;
            rm_q         <= rm_d;
            wp_q         <= wp_d;
            w_q          <= w_d;
            bw16_q       <= bw16_d;
            bw32_q       <= bw32_d;
            as32_q       <= as32_d;
            lock_q       <= lock_d;
            rep_q        <= rep_d;
            repne_q      <= repne_d;
            segv_q       <= segv_d;
            seg_q        <= seg_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_pfx_d     = op_pfx_q;
        ad_pfx_d     = ad_pfx_q;
        byte_ready_d = byte_ready_q;
        out_valid_d  = out_valid_q;
        opcode_d     = opcode_q;
        two_byte_d   = two_byte_q;
        has_modrm_d  = has_modrm_q;
        mod_d        = mod_q;
        ireg_d       = ireg_q;
        rm_d         = rm_q;
        wp_d         = wp_q;
        w_d          = w_q;
        bw16_d       = bw16_q;
        bw32_d       = bw32_q;
        as32_d       = as32_q;
        lock_d       = lock_q;
        rep_d        = rep_q;
        repne_d      = repne_q;
        segv_d       = segv_q;
        seg_d        = seg_q;
        fault_d      = fault_q;

        case (state_q)
            S_PREFIX: begin
                if (byte_valid) begin
                    if (is_prefix(byte_data)) begin
                        case (byte_data)
                            8'h66:   op_pfx_d = 1'b1;
                            8'h67:   ad_pfx_d = 1'b1;
                            8'hF0:   lock_d   = 1'b1;
                            8'hF3:   rep_d    = 1'b1;
                            8'hF2:   repne_d  = 1'b1;
                            default: begin
                                segv_d = 1'b1;
                                seg_d  = seg_code(byte_data);
                            end
                        endcase
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(MAX_LEN - 1)) begin
                            state_d = S_FAULT;
                            fault_d = 1'b1;
                        end
                    end else begin
                        opcode_d = byte_data;
                        bw32_d   = cs_d ^ op_pfx_q;
                        bw16_d   = ~(cs_d ^ op_pfx_q);
                        as32_d   = cs_d ^ ad_pfx_q;
                        mod_d    = 2'd0;
                        rm_d     = 3'd0;
                        if (byte_data == 8'h0F) begin
                            two_byte_d = 1'b1;
                            wp_d       = 1'b0;
                            w_d        = 1'b0;
                            ireg_d     = 3'd0;
                            state_d    = S_OPCODE2;
                        end else begin
                            // MOV r,imm (B0-BF) keeps its w bit in opcode[3]
                            if (byte_data[7:4] == 4'hB) begin
                                wp_d = 1'b1;
                                w_d  = byte_data[3];
                            end else if (w_in_bit0(byte_data)) begin
                                wp_d = 1'b1;
                                w_d  = byte_data[0];
                            end else begin
                                wp_d = 1'b0;
                                w_d  = 1'b0;
                            end
                            ireg_d  = reg_in_opcode(byte_data) ? byte_data[2:0] : 3'd0;
                            state_d = modrm_1b(byte_data) ? S_MODRM : S_OUT;
                        end
                    end
                end
            end
            S_OPCODE2: begin
                if (byte_valid) begin
                    opcode_d = byte_data;
                    state_d  = modrm_2b(byte_data) ? S_MODRM : S_OUT;
                end
            end
            S_MODRM: begin
                if (byte_valid) begin
                    mod_d       = byte_data[7:6];
                    ireg_d      = byte_data[5:3];
                    rm_d        = byte_data[2:0];
                    has_modrm_d = 1'b1;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                if (instr_end) begin
                    cnt_d       = '0;
                    op_pfx_d    = 1'b0;
                    ad_pfx_d    = 1'b0;
                    lock_d      = 1'b0;
                    rep_d       = 1'b0;
                    repne_d     = 1'b0;
                    segv_d      = 1'b0;
                    seg_d       = 3'd0;
                    has_modrm_d = 1'b0;
                    two_byte_d  = 1'b0;
                    state_d     = S_PREFIX;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_PREFIX;
            end
        endcase

        // Handshake flags are registered copies of where the FSM lands next
        byte_ready_d = (state_d == S_PREFIX) || (state_d == S_OPCODE2) || (state_d == S_MODRM);
        out_valid_d  = (state_d == S_OUT);
    end

    assign byte_ready      = byte_ready_q;
    assign out_valid       = out_valid_q;
    assign opcode          = opcode_q;
    assign two_byte        = two_byte_q;
    assign has_modrm       = has_modrm_q;
    assign mod             = mod_q;
    assign instruction_reg = ireg_q;
    assign rm              = rm_q;
    assign w_is_present    = wp_q;
    assign w               = w_q;
    assign bit_width_16    = bw16_q;
    assign bit_width_32    = bw32_q;
    assign addr_size_32    = as32_q;
    assign lock            = lock_q;
    assign rep             = rep_q;
    assign repne           = repne_q;
    assign seg_valid       = segv_q;
    assign seg             = seg_q;
    assign fault           = fault_q;

endmodule

// File: doc/decode_prefix_modrm.md
Name: decode_prefix_modrm

Overview:
- Byte-serial front stage of the decode unit, directly upstream of decode_general_register.
- Pulls instruction bytes from the prefetch queue and absorbs prefixes, the opcode (one- or two-byte) and the ModRM byte.
- Presents a registered record with instruction_reg, w_is_present, w, bit_width_16 and bit_width_32, which feed decode_general_register directly.
- Hands the byte stream to the displacement/immediate stage and waits for end-of-instruction.

Parameters:
- MAX_LEN, 15, maximum instruction length in bytes; a prefix run reaching MAX_LEN bytes raises fault.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- byte_valid  input  1  prefetch byte available
- byte_data  input  8  prefetch byte
- byte_ready  output  1  byte consumed this cycle when byte_valid & byte_ready
- cs_d  input  1  code segment default size (1 = 32-bit), sampled at opcode byte
- out_valid  output  1  decoded record valid
- out_ready  input  1  downstream accepts record
- instr_end  input  1  pulse from length stage: instruction fully consumed
- opcode  output  8  primary or second opcode byte
- two_byte  output  1  opcode was 0x0F-escaped
- has_modrm  output  1  ModRM fields valid
- mod  output  2  ModRM[7:6]
- instruction_reg  output  3  ModRM[5:3], or opcode[2:0] for register-in-opcode forms
- rm  output  3  ModRM[2:0]
- w_is_present  output  1  opcode carries a w bit
- w  output  1  w bit value
- bit_width_16  output  1  effective operand size is 16
- bit_width_32  output  1  effective operand size is 32
- addr_size_32  output  1  effective address size is 32
- lock, rep, repne  output  1 each  prefix flags
- seg_valid  output  1  segment override present
- seg  output  3  ES=0 CS=1 SS=2 DS=3 FS=4 GS=5
- fault  output  1  prefix overflow (sticky until reset)

Behaviour:
- States: PREFIX, OPCODE2, MODRM, OUT, WAIT_END, FAULT. Reset: state=PREFIX and every output 0, except byte_ready=1.
- byte_ready=1 only in PREFIX, OPCODE2 and MODRM. All outputs are registered and hold steady in OUT and WAIT_END.
- PREFIX, prefix bytes, each consumed in one cycle:
  - 0x66 sets op_pfx; 0x67 sets ad_pfx; 0xF0 sets lock; 0xF3 sets rep; 0xF2 sets repne.
  - 0x26/2E/36/3E/64/65 set seg_valid and seg; the last segment prefix wins. Repeated prefixes are legal.
  - prefix_count increments per prefix. If the count reaches MAX_LEN: go to FAULT with fault=1 and byte_ready=0; only reset leaves FAULT.
- PREFIX, non-prefix byte: latch opcode.
  - Derive bit_width_32 = cs_d ^ op_pfx, bit_width_16 = ~bit_width_32, addr_size_32 = cs_d ^ ad_pfx.
  - Byte 0x0F: go to OPCODE2 with two_byte=1.
  - Byte with ModRM: go to MODRM.
  - Any other byte: go to OUT.
- One-byte ModRM set: opcode[7:6]==00 with opcode[2]==0 (ALU r/m forms); 0x62, 0x63, 0x69, 0x6B; 0x80–0x8F; 0xC0, 0xC1, 0xC6, 0xC7; 0xD0–0xD3; 0xF6, 0xF7, 0xFE, 0xFF.
- Two-byte ModRM set: all second bytes except 0x80–0x8F and 0xA0, 0xA1, 0xA8, 0xA9.
- w_is_present/w rules:
  - ALU forms, 0x84–0x87, 0x88–0x8B, 0xC6/C7, 0xD0–D3, 0xF6/F7, 0xFE/FF: w_is_present=1, w=opcode[0].
  - 0xB0–0xBF: w_is_present=1, w=opcode[3], instruction_reg=opcode[2:0], no ModRM.
  - 0x40–0x5F and 0x90–0x97: w_is_present=0, instruction_reg=opcode[2:0].
  - All others: w_is_present=0, w=0.
- MODRM: consume one byte, latch mod/reg/rm, set has_modrm=1, go to OUT.
- OUT: out_valid=1. On out_ready, clear out_valid and go to WAIT_END.
- WAIT_END: on instr_end, clear all prefix flags, has_modrm, two_byte and prefix_count; return to PREFIX. The first byte_ready is asserted the following cycle.
- instr_end outside WAIT_END is ignored. byte_valid=0 in any fetch state stalls with no state change.
- Reset mid-instruction discards partial state in the same cycle.

Test Plan:
- cs_d=1; bytes 0x01,0xD8 (ADD EAX-form, ModRM 11_011_000) -> out_valid after 2 accepted bytes; opcode=0x01, has_modrm=1, mod=3, instruction_reg=3, rm=0, w_is_present=1, w=1, bit_width_32=1.
- cs_d=1; bytes 0x66,0x88,0xC1 -> bit_width_16=1, w=0, instruction_reg=0, rm=1; out_valid held with byte_ready=0 until out_ready; then instr_end returns to PREFIX.
- cs_d=0; bytes 0x26,0x64,0xF3,0xB5 -> seg_valid=1, seg=4, rep=1, has_modrm=0, instruction_reg=5, w=0, bit_width_16=1.
- bytes 0x0F,0xAF,0xC3 -> two_byte=1, opcode=0xAF, instruction_reg=0, rm=3, w_is_present=0; bytes 0x0F,0x84 -> has_modrm=0.
- 15 consecutive 0x66 bytes -> fault=1 after 15th accepted, byte_ready=0 thereafter; reset clears fault and resumes.
- byte_valid toggled every other cycle during 0x67,0x8B,0x05 plus reset asserted mid-sequence -> no byte lost before reset; all outputs 0 and state PREFIX the cycle after reset.
